// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline control block: FSM state codes, the
// operand-forward select values seen by the ALU-input muxes, and a small
// register-hit helper used by both the hazard and the forwarding logic.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int PHASE_CNT_W = 3;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_STALL = 2'd1;
    localparam logic [1:0] STATE_FLUSH = 2'd2;
    localparam logic [1:0] STATE_EXC   = 2'd3;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    // A later stage "hits" a source operand when it writes the same register.
    // Register 0 is deliberately not treated specially.
    function automatic logic regHit(
        input logic                  doWrite,
        input logic [REG_ADDR_W-1:0] dstAddr,
        input logic [REG_ADDR_W-1:0] srcAddr
    );
        return doWrite && (dstAddr == srcAddr);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forward select for one source operand of the decode instruction.
// The MEM stage holds the younger result, so it wins over WB on a double hit.
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] srcAddr,
    input  logic                  memDoRegWrite,
    input  logic [REG_ADDR_W-1:0] memWriteRegAddr,
    input  logic                  wbDoRegWrite,
    input  logic [REG_ADDR_W-1:0] wbWriteRegAddr,
    output logic [1:0]            fwdSel
);

    // Pick the youngest in-flight producer of this operand.
    always_comb begin
        fwdSel = FWD_REGFILE;
        if (regHit(memDoRegWrite, memWriteRegAddr, srcAddr)) begin
            fwdSel = FWD_MEM;
        end else if (regHit(wbDoRegWrite, wbWriteRegAddr, srcAddr)) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall / flush / forwarding controller. Sequences load-use bubbles,
// taken-branch flushes and overflow exception redirects, and counts the
// cycles spent injecting bubbles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W         = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [REG_ADDR_W-1:0]  iID_ra_addr,
    input  logic [REG_ADDR_W-1:0]  iID_rb_addr,
    input  logic                   iID_uses_rb,
    input  logic                   iEX_do_dm_read,
    input  logic                   iEX_do_reg_write,
    input  logic [REG_ADDR_W-1:0]  iEX_write_reg_addr,
    input  logic                   iMEM_do_reg_write,
    input  logic [REG_ADDR_W-1:0]  iMEM_write_reg_addr,
    input  logic                   iWB_do_reg_write,
    input  logic [REG_ADDR_W-1:0]  iWB_write_reg_addr,
    input  logic                   iEX_branch_taken,
    input  logic                   iMEM_alu_overflow,
    output logic                   oDo_flush_REG1,
    output logic                   oDo_flush_REG2,
    output logic                   oDo_flush_REG3,
    output logic                   oDo_flush_REG4,
    output logic                   oDo_hazard,
    output logic                   oPc_stall,
    output logic [1:0]             oFwd_ra_sel,
    output logic [1:0]             oFwd_rb_sel,
    output logic                   oExc_redirect,
    output logic [STALL_CNT_W-1:0] oStall_count
);

    localparam logic [PHASE_CNT_W-1:0] LOAD_RELOAD   = PHASE_CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] BRANCH_RELOAD = PHASE_CNT_W'(BRANCH_FLUSH_CYCLES - 1);

    logic [1:0]             stateReg, stateNext;
    logic [PHASE_CNT_W-1:0] cntReg, cntNext;
    logic [STALL_CNT_W-1:0] stallCountReg;
    logic                   loadUse;
    logic                   hazard;

    // Decode reads a register that the load now in EX has not yet fetched.
    assign loadUse = iEX_do_dm_read && iEX_do_reg_write &&
                     (regHit(1'b1, iEX_write_reg_addr, iID_ra_addr) ||
                      (iID_uses_rb && regHit(1'b1, iEX_write_reg_addr, iID_rb_addr)));

    // Next-state logic, priority EXC > FLUSH > STALL. The IDLE cycle that
    // detects a load-use hazard is already the first bubble, so STALL only
    // covers the remaining LOAD_STALL_CYCLES-1 cycles and leaves on cnt==1.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            STATE_IDLE: begin
                if (iMEM_alu_overflow) begin
                    stateNext = STATE_EXC;
                end else if (iEX_branch_taken) begin
                    stateNext = STATE_FLUSH;
                    cntNext   = BRANCH_RELOAD;
                end else if (loadUse) begin
                    cntNext = LOAD_RELOAD;
                    if (LOAD_STALL_CYCLES > 1) begin
                        stateNext = STATE_STALL;
                    end
                end
            end
            STATE_STALL: begin
                if (iMEM_alu_overflow) begin
                    stateNext = STATE_EXC;
                end else if (iEX_branch_taken) begin
                    stateNext = STATE_FLUSH;
                    cntNext   = BRANCH_RELOAD;
                end else if (cntReg <= PHASE_CNT_W'(1)) begin
                    stateNext = STATE_IDLE;
                end else begin
                    cntNext = cntReg - PHASE_CNT_W'(1);
                end
            end
            STATE_FLUSH: begin
                if (iMEM_alu_overflow) begin
                    stateNext = STATE_EXC;
                end else if (cntReg == '0) begin
                    stateNext = STATE_IDLE;
                end else begin
                    cntNext = cntReg - PHASE_CNT_W'(1);
                end
            end
            default: begin
                stateNext = STATE_IDLE;
            end
        endcase
    end

    // State and phase counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= STATE_IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    // Bubble request: immediate in IDLE unless a redirect takes precedence,
    // and held for the whole STALL state.
    always_comb begin
        hazard = (stateReg == STATE_STALL) ||
                 ((stateReg == STATE_IDLE) && loadUse &&
                  !iMEM_alu_overflow && !iEX_branch_taken);
    end

    // Saturating count of bubble cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCountReg <= '0;
        end else if (hazard && (stallCountReg != '1)) begin
            stallCountReg <= stallCountReg + STALL_CNT_W'(1);
        end
    end

    assign oDo_hazard     = hazard;
    assign oPc_stall      = hazard;
    assign oDo_flush_REG1 = (stateReg == STATE_FLUSH) || (stateReg == STATE_EXC);
    assign oDo_flush_REG2 = (stateReg == STATE_FLUSH) || (stateReg == STATE_EXC);
    assign oDo_flush_REG3 = (stateReg == STATE_EXC);
    assign oDo_flush_REG4 = 1'b0;
    assign oExc_redirect  = (stateReg == STATE_EXC);
    assign oStall_count   = stallCountReg;

    pipeline_ctrl_fwd_unit raFwd (
        .srcAddr         (iID_ra_addr),
        .memDoRegWrite   (iMEM_do_reg_write),
        .memWriteRegAddr (iMEM_write_reg_addr),
        .wbDoRegWrite    (iWB_do_reg_write),
        .wbWriteRegAddr  (iWB_write_reg_addr),
        .fwdSel          (oFwd_ra_sel)
    );

    pipeline_ctrl_fwd_unit rbFwd (
        .srcAddr         (iID_rb_addr),
        .memDoRegWrite   (iMEM_do_reg_write),
        .memWriteRegAddr (iMEM_write_reg_addr),
        .wbDoRegWrite    (iWB_do_reg_write),
        .wbWriteRegAddr  (iWB_write_reg_addr),
        .fwdSel          (oFwd_rb_sel)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for the combinational
// hazard/forward paths, then hand-written multi-cycle sequences.
module tb_pipeline_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] raAddr, rbAddr, exAddr, memAddr, wbAddr;
    logic       usesRb, exLoad, exWrite, memWrite, wbWrite, branch, ovf;

    logic        f1, f2, f3, f4, hz, pc, redir;
    logic [1:0]  fra, frb;
    logic [15:0] cnt;
    logic        f1b, f2b, f3b, f4b, hzb, pcb, redirb;
    logic [1:0]  frab, frbb;
    logic [15:0] cntb;

    int testsRun = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeline_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .iID_ra_addr(raAddr), .iID_rb_addr(rbAddr), .iID_uses_rb(usesRb),
        .iEX_do_dm_read(exLoad), .iEX_do_reg_write(exWrite), .iEX_write_reg_addr(exAddr),
        .iMEM_do_reg_write(memWrite), .iMEM_write_reg_addr(memAddr),
        .iWB_do_reg_write(wbWrite), .iWB_write_reg_addr(wbAddr),
        .iEX_branch_taken(branch), .iMEM_alu_overflow(ovf),
        .oDo_flush_REG1(f1), .oDo_flush_REG2(f2), .oDo_flush_REG3(f3), .oDo_flush_REG4(f4),
        .oDo_hazard(hz), .oPc_stall(pc), .oFwd_ra_sel(fra), .oFwd_rb_sel(frb),
        .oExc_redirect(redir), .oStall_count(cnt)
    );

    pipeline_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .iID_ra_addr(raAddr), .iID_rb_addr(rbAddr), .iID_uses_rb(usesRb),
        .iEX_do_dm_read(exLoad), .iEX_do_reg_write(exWrite), .iEX_write_reg_addr(exAddr),
        .iMEM_do_reg_write(memWrite), .iMEM_write_reg_addr(memAddr),
        .iWB_do_reg_write(wbWrite), .iWB_write_reg_addr(wbAddr),
        .iEX_branch_taken(branch), .iMEM_alu_overflow(ovf),
        .oDo_flush_REG1(f1b), .oDo_flush_REG2(f2b), .oDo_flush_REG3(f3b), .oDo_flush_REG4(f4b),
        .oDo_hazard(hzb), .oPc_stall(pcb), .oFwd_ra_sel(frab), .oFwd_rb_sel(frbb),
        .oExc_redirect(redirb), .oStall_count(cntb)
    );

    typedef struct packed {
        logic [4:0] ra;
        logic [4:0] rb;
        logic       usesRb;
        logic       exLoad;
        logic       exWrite;
        logic [4:0] exAddr;
        logic       memWrite;
        logic [4:0] memAddr;
        logic       wbWrite;
        logic [4:0] wbAddr;
        logic       expHazard;
        logic [1:0] expRa;
        logic [1:0] expRb;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        raAddr = 5'd1; rbAddr = 5'd2; usesRb = 1'b0;
        exLoad = 1'b0; exWrite = 1'b0; exAddr = 5'd0;
        memWrite = 1'b0; memAddr = 5'd0; wbWrite = 1'b0; wbAddr = 5'd0;
        branch = 1'b0; ovf = 1'b0;
    endtask

    // Drive a load of r3 in EX with decode reading ra=r3.
    task automatic driveLoadUse();
        raAddr = 5'd3; rbAddr = 5'd1; usesRb = 1'b1;
        exLoad = 1'b1; exWrite = 1'b1; exAddr = 5'd3;
    endtask

    // Move 1 time unit past the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        idleInputs();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int expCount;

        // ra, rb, usesRb, exLoad, exWrite, exAddr, memW, memA, wbW, wbA, hz, fwdRa, fwdRb
        vecs[0]  = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{5'd1, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'b00, 2'b00};
        vecs[4]  = '{5'd3, 5'd1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{5'd3, 5'd1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 2'b01, 2'b01};
        vecs[7]  = '{5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 2'b10, 2'b10};
        vecs[8]  = '{5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 2'b00, 2'b00};
        vecs[9]  = '{5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 2'b01, 2'b10};
        vecs[10] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 2'b01};

        // Reset state
        idleInputs();
        #3;
        check("reset_hazard", {31'd0, hz}, 32'd0);
        check("reset_flush1", {31'd0, f1}, 32'd0);
        check("reset_redirect", {31'd0, redir}, 32'd0);
        check("reset_count", {16'd0, cnt}, 32'd0);
        doReset();

        // Vector table on the single-bubble instance (stays IDLE on load-use)
        expCount = 0;
        for (int i = 0; i < NVEC; i++) begin
            step();
            raAddr = vecs[i].ra; rbAddr = vecs[i].rb; usesRb = vecs[i].usesRb;
            exLoad = vecs[i].exLoad; exWrite = vecs[i].exWrite; exAddr = vecs[i].exAddr;
            memWrite = vecs[i].memWrite; memAddr = vecs[i].memAddr;
            wbWrite = vecs[i].wbWrite; wbAddr = vecs[i].wbAddr;
            #2;
            $display("[TB] vec %0d: hz=%0b fwd_ra=%0b fwd_rb=%0b count=%0d", i, hz, fra, frb, cnt);
            check($sformatf("vec%0d_hazard", i), {31'd0, hz}, {31'd0, vecs[i].expHazard});
            check($sformatf("vec%0d_pcstall", i), {31'd0, pc}, {31'd0, vecs[i].expHazard});
            check($sformatf("vec%0d_fwd_ra", i), {30'd0, fra}, {30'd0, vecs[i].expRa});
            check($sformatf("vec%0d_fwd_rb", i), {30'd0, frb}, {30'd0, vecs[i].expRb});
            check($sformatf("vec%0d_count", i), {16'd0, cnt}, expCount);
            if (vecs[i].expHazard) expCount++;
        end
        step(); idleInputs(); #2;
        check("vec_count_final", {16'd0, cnt}, expCount);

        // Single-cycle load-use bubble
        doReset();
        step(); driveLoadUse(); #2;
        $display("[TB] loaduse1 c0: hz=%0b pc=%0b", hz, pc);
        check("lu1_hz_c0", {31'd0, hz}, 32'd1);
        check("lu1_pc_c0", {31'd0, pc}, 32'd1);
        step(); idleInputs(); #2;
        $display("[TB] loaduse1 c1: hz=%0b count=%0d", hz, cnt);
        check("lu1_hz_c1", {31'd0, hz}, 32'd0);
        check("lu1_count", {16'd0, cnt}, 32'd1);

        // Three-cycle load-use bubble
        doReset();
        step(); driveLoadUse(); #2;
        check("lu3_hz_c0", {31'd0, hzb}, 32'd1);
        step(); idleInputs(); #2;
        check("lu3_hz_c1", {31'd0, hzb}, 32'd1);
        check("lu3_pc_c1", {31'd0, pcb}, 32'd1);
        step(); #2;
        check("lu3_hz_c2", {31'd0, hzb}, 32'd1);
        step(); #2;
        $display("[TB] loaduse3 end: hz=%0b count=%0d", hzb, cntb);
        check("lu3_hz_c3", {31'd0, hzb}, 32'd0);
        check("lu3_count", {16'd0, cntb}, 32'd3);

        // Overflow preempts a stall in progress
        doReset();
        step(); driveLoadUse(); #2;
        step(); idleInputs(); ovf = 1'b1; #2;
        check("stall_ovf_hz", {31'd0, hzb}, 32'd1);
        step(); ovf = 1'b0; #2;
        $display("[TB] stall->exc: redir=%0b hz=%0b", redirb, hzb);
        check("stall_ovf_redir", {31'd0, redirb}, 32'd1);
        check("stall_ovf_hz_exc", {31'd0, hzb}, 32'd0);
        step(); #2;
        check("stall_ovf_after", {31'd0, redirb}, 32'd0);

        // Taken branch: two flush cycles, load-use suppressed during them
        doReset();
        step(); branch = 1'b1; #2;
        check("br_flush_c0", {31'd0, f1}, 32'd0);
        step(); branch = 1'b0; driveLoadUse(); #2;
        $display("[TB] branch c1: f1=%0b f2=%0b f3=%0b pc=%0b", f1, f2, f3, pc);
        check("br_f1_c1", {31'd0, f1}, 32'd1);
        check("br_f2_c1", {31'd0, f2}, 32'd1);
        check("br_f3_c1", {31'd0, f3}, 32'd0);
        check("br_pc_c1", {31'd0, pc}, 32'd0);
        step(); #2;
        check("br_f1_c2", {31'd0, f1}, 32'd1);
        check("br_f2_c2", {31'd0, f2}, 32'd1);
        check("br_pc_c2", {31'd0, pc}, 32'd0);
        step(); idleInputs(); #2;
        check("br_f1_c3", {31'd0, f1}, 32'd0);
        check("br_f2_c3", {31'd0, f2}, 32'd0);

        // Overflow and branch together: exception only
        doReset();
        step(); branch = 1'b1; ovf = 1'b1; #2;
        step(); branch = 1'b0; ovf = 1'b0; #2;
        $display("[TB] exc c1: f1=%0b f2=%0b f3=%0b redir=%0b", f1, f2, f3, redir);
        check("exc_f1", {31'd0, f1}, 32'd1);
        check("exc_f2", {31'd0, f2}, 32'd1);
        check("exc_f3", {31'd0, f3}, 32'd1);
        check("exc_f4", {31'd0, f4}, 32'd0);
        check("exc_redir", {31'd0, redir}, 32'd1);
        step(); #2;
        check("exc_after_f1", {31'd0, f1}, 32'd0);
        check("exc_after_f2", {31'd0, f2}, 32'd0);
        check("exc_after_redir", {31'd0, redir}, 32'd0);
        step(); #2;
        check("exc_after2_f1", {31'd0, f1}, 32'd0);

        // Stall counter saturation
        doReset();
        step(); driveLoadUse();
        repeat (65540) step();
        idleInputs();
        step(); #2;
        $display("[TB] saturation: count=0x%0h", cnt);
        check("count_saturated", {16'd0, cnt}, 32'h0000_FFFF);

        // Asynchronous reset in the middle of a flush
        step(); branch = 1'b1; #2;
        step(); branch = 1'b0; #2;
        check("midflush_f1", {31'd0, f1}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        $display("[TB] async reset: f1=%0b f2=%0b count=%0d", f1, f2, cnt);
        check("rst_f1", {31'd0, f1}, 32'd0);
        check("rst_f2", {31'd0, f2}, 32'd0);
        check("rst_f3", {31'd0, f3}, 32'd0);
        check("rst_hz", {31'd0, hz}, 32'd0);
        check("rst_pc", {31'd0, pc}, 32'd0);
        check("rst_redir", {31'd0, redir}, 32'd0);
        check("rst_count", {16'd0, cnt}, 32'd0);
        check("rst_fwd", {28'd0, fra, frb}, 32'd0);
        step(); #2 reset_n = 1'b1;
        step(); #2;
        check("post_rst_f1", {31'd0, f1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
